// File: rtl/mem_arbiter.sv
// Two-port arbiter that shares one cache-line memory interface between the dcache (port 0) and the icache (port 1).
// Define ARB_ROUND_ROBIN_EN to alternate tie grants; without it, port 0 always wins ties.
module mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 256,
    parameter int MAX_WAIT = 64,
    parameter int CNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              p0_enable_i,
    input  logic              p0_write_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [DATA_W-1:0] p0_data_i,
    output logic [DATA_W-1:0] p0_data_o,
    output logic              p0_ack_o,
    input  logic              p1_enable_i,
    input  logic              p1_write_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [DATA_W-1:0] p1_data_i,
    output logic [DATA_W-1:0] p1_data_o,
    output logic              p1_ack_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [DATA_W-1:0] mem_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [1:0]        grant_o,
    output logic              timeout_o,
    output logic [CNT_W-1:0]  p0_grants_o,
    output logic [CNT_W-1:0]  p1_grants_o
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state_q, state_d;
    logic                memEnable_q, memEnable_d;
    logic                memWrite_q, memWrite_d;
    logic [ADDR_W-1:0]   memAddr_q, memAddr_d;
    logic [DATA_W-1:0]   memData_q, memData_d;
    logic [1:0]          grant_q, grant_d;
    logic                lastGrant_q, lastGrant_d;
    logic [WAIT_W-1:0]   waitCnt_q, waitCnt_d;
    logic                timeout_q, timeout_d;
    logic [CNT_W-1:0]    p0Grants_q, p0Grants_d;
    logic [CNT_W-1:0]    p1Grants_q, p1Grants_d;
    logic                pickP1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            memEnable_q <= 1'b0;
            memWrite_q  <= 1'b0;
            memAddr_q   <= '0;
            memData_q   <= '0;
            grant_q     <= 2'b00;
            lastGrant_q <= 1'b1;
            waitCnt_q   <= '0;
            timeout_q   <= 1'b0;
            p0Grants_q  <= '0;
            p1Grants_q  <= '0;
        end else begin
            state_q     <= state_d;
            memEnable_q <= memEnable_d;
            memWrite_q  <= memWrite_d;
            memAddr_q   <= memAddr_d;
            memData_q   <= memData_d;
            grant_q     <= grant_d;
            lastGrant_q <= lastGrant_d;
            waitCnt_q   <= waitCnt_d;
            timeout_q   <= timeout_d;
            p0Grants_q  <= p0Grants_d;
            p1Grants_q  <= p1Grants_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        memEnable_d = memEnable_q;
        memWrite_d  = memWrite_q;
        memAddr_d   = memAddr_q;
        memData_d   = memData_q;
        grant_d     = grant_q;
        lastGrant_d = lastGrant_q;
        waitCnt_d   = waitCnt_q;
        timeout_d   = timeout_q;
        p0Grants_d  = p0Grants_q;
        p1Grants_d  = p1Grants_q;
        pickP1      = 1'b0;

`ifdef ARB_ROUND_ROBIN_EN
        // lastGrant_q == 1 means port 1 was served last, so port 0 takes the next tie.
        pickP1 = p1_enable_i && (!p0_enable_i || !lastGrant_q);
`else
        pickP1 = p1_enable_i && !p0_enable_i;
`endif

        case (state_q)
            IDLE: begin
                waitCnt_d = '0;
                if (p0_enable_i || p1_enable_i) begin
                    state_d     = BUSY;
                    memEnable_d = 1'b1;
                    lastGrant_d = pickP1;
                    if (pickP1) begin
                        memAddr_d  = p1_addr_i;
                        memData_d  = p1_data_i;
                        memWrite_d = p1_write_i;
                        grant_d    = 2'b10;
                        p1Grants_d = p1Grants_q + CNT_W'(1);
                    end else begin
                        memAddr_d  = p0_addr_i;
                        memData_d  = p0_data_i;
                        memWrite_d = p0_write_i;
                        grant_d    = 2'b01;
                        p0Grants_d = p0Grants_q + CNT_W'(1);
                    end
                end
            end
            BUSY: begin
                if (mem_ack_i) begin
                    state_d     = IDLE;
                    memEnable_d = 1'b0;
                    grant_d     = 2'b00;
                    waitCnt_d   = '0;
                end else begin
                    // Saturate so a stuck memory can never wrap the counter back to zero.
                    if (waitCnt_q != WAIT_LIMIT) begin
                        waitCnt_d = waitCnt_q + WAIT_W'(1);
                    end
                    if (waitCnt_d == WAIT_LIMIT) begin
                        timeout_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign p0_ack_o     = (state_q == BUSY) && grant_q[0] && mem_ack_i;
    assign p1_ack_o     = (state_q == BUSY) && grant_q[1] && mem_ack_i;
    assign p0_data_o    = mem_data_i;
    assign p1_data_o    = mem_data_i;
    assign mem_enable_o = memEnable_q;
    assign mem_write_o  = memWrite_q;
    assign mem_addr_o   = memAddr_q;
    assign mem_data_o   = memData_q;
    assign grant_o      = grant_q;
    assign timeout_o    = timeout_q;
    assign p0_grants_o  = p0Grants_q;
    assign p1_grants_o  = p1Grants_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single 256-bit off-chip memory interface between two cache requesters: port 0 is the data cache and port 1 is the instruction cache.
Accepts one line transaction at a time, forwards it to memory, holds it until mem_ack_i, then returns the ack to the winning requester only.
Sits between the CPU's cache tops and the testbench Data_Memory model.
Also keeps a wait-cycle watchdog and per-port grant counters for debug.

Parameters:
ADDR_W, 32, memory address width
DATA_W, 256, cache line width
MAX_WAIT, 64, cycles in BUSY without ack before timeout_o sets
CNT_W, 16, width of per-port grant counters

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
p0_enable_i  in  1  dcache request; held until p0_ack_o
p0_write_i  in  1  dcache request is a write
p0_addr_i  in  ADDR_W  dcache line address
p0_data_i  in  DATA_W  dcache write line
p0_data_o  out  DATA_W  read line to dcache
p0_ack_o  out  1  transaction done for port 0
p1_enable_i, p1_write_i, p1_addr_i, p1_data_i, p1_data_o, p1_ack_o  same widths and roles, icache side
mem_data_i  in  DATA_W  read line from memory
mem_ack_i  in  1  memory done
mem_data_o  out  DATA_W  write line to memory
mem_addr_o  out  ADDR_W  address to memory
mem_enable_o  out  1  memory request
mem_write_o  out  1  memory write
grant_o  out  2  one-hot owner of the current transaction; 00 when idle
timeout_o  out  1  sticky watchdog flag
p0_grants_o  out  CNT_W  port 0 grant count
p1_grants_o  out  CNT_W  port 1 grant count

Behaviour:
- Reset values: every output is 0 and the FSM is in IDLE.
  - last_grant resets to 1, so port 0 wins the first tie.
  - The wait counter resets to 0.
- FSM states: IDLE and BUSY.
- In IDLE with any request:
  - Select the winner by the arbitration rule.
  - Latch the winner's addr, data and write into the output registers.
  - Set grant_o and update last_grant.
  - Increment that port's grant counter, which wraps at 2^CNT_W.
  - Go to BUSY.
  - mem_enable_o rises the cycle after the request is first seen; minimum request-to-enable latency is 1 cycle.
- In BUSY:
  - mem_enable_o, mem_addr_o, mem_write_o and mem_data_o are held constant.
  - On mem_ack_i, px_ack_o of the granted port is driven high combinationally in the same cycle.
  - Next edge: clear mem_enable_o and grant_o, return to IDLE.
- There is always at least one IDLE cycle between transactions.
  - A requester still holding enable in that IDLE cycle is treated as a new request.
  - Caches must drop enable the cycle after ack.
- p0_data_o and p1_data_o continuously mirror mem_data_i. Requesters sample them only when their ack is high.
- Boundary and corner cases:
  - mem_ack_i while in IDLE is ignored; no ack is forwarded.
  - A requester that drops enable mid-BUSY does not abort the transaction; it completes and the ack still pulses.
  - The losing requester's enable, and any inputs changing during BUSY, have no effect until IDLE.
  - Watchdog: the counter increments each BUSY cycle without ack and clears on ack or in IDLE. When it reaches MAX_WAIT, timeout_o sets and stays set until reset. The transaction keeps waiting.
  - rst_i mid-transaction: everything returns to reset values immediately. Any ack in that cycle is not forwarded.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined: when both ports request in IDLE, the grant goes to the port not in last_grant. A single requester always wins.
- Undefined: fixed priority, port 0 (dcache) always wins ties. last_grant is still maintained but not used.

Test Plan:
- Single read, p0: addr 0x400, mem_ack_i 10 cycles after mem_enable_o.
  -> mem_enable_o high 1 cycle after request; mem_addr_o=0x400, mem_write_o=0.
  -> p0_ack_o high in the ack cycle with p0_data_o=mem_data_i; p1_ack_o stays 0; grant_o=01 then 00.
- Single write, p1: addr 0x80, data 0xA5...A5.
  -> mem_write_o=1, mem_data_o=0xA5...A5 held all of BUSY.
  -> p1_ack_o pulses; p1_grants_o=1.
- Tie: both ports request continuously for 4 transactions.
  -> With ARB_ROUND_ROBIN_EN: order p0,p1,p0,p1.
  -> Without it: p0 wins every transaction.
- Input changes mid-BUSY: p0_addr_i changes and p0_enable_i drops mid-BUSY.
  -> mem_addr_o unchanged; p0_ack_o still pulses on mem_ack_i.
- Stray ack and watchdog:
  -> mem_ack_i pulse in IDLE: no px_ack_o.
  -> With MAX_WAIT=64, withholding ack: timeout_o sets after 64 BUSY cycles and stays 1 after a later ack.
- Reset mid-BUSY: rst_i asserted mid-BUSY.
  -> mem_enable_o, grant_o and the counters are 0 the same cycle; the next tie goes to p0.
